accel_conditioner: RTL and testbench
====================================

# accel_conditioner

Conditions raw accelerometer samples into the scaled magnitudes shown by the VGA text overlay. It accepts signed per-axis samples from the accelerometer reader and box-averages the absolute values over 2^AVG_LOG2 samples. It then scales each axis to 0..999 with saturation and presents `data_x`/`data_y`/`data_z` to the display stage. All three outputs update together and stay stable between updates.

## Interface
- `AVG_LOG2`, default 3: log2 of samples averaged per update (1..6).
- `SCALE_MUL`, default 1000: unsigned 16-bit multiplier applied to the averaged magnitude.
- `SCALE_SHIFT`, default 9: right shift after the multiply. With the defaults, 512 counts (2 g at 256 LSB/g) maps to 1000.
- `MAX10_CLK1_50`  in  1: system clock, 50 MHz.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `raw_x`, `raw_y`, `raw_z`  in  16 each: signed two's-complement samples, valid together.
- `raw_valid`  in  1: single-cycle strobe qualifying `raw_*`.
- `raw_ready`  out  1: high when a sample can be accepted.
- `data_x`, `data_y`, `data_z`  out  16 each: scaled magnitudes, 0..999.
- `data_update`  out  1: one-cycle pulse on the cycle new `data_*` values first appear.
- `overrun`  out  1: sticky flag; set when a sample is offered while `raw_ready` is low.

## Operation
- States: ACCUM, SCALE_X, SCALE_Y, SCALE_Z, COMMIT. Reset enters ACCUM.
- `raw_ready` = (state == ACCUM).
- ACCUM behaviour:
  - On `raw_valid && raw_ready`, add |raw_a| to the 17-bit-extended accumulator of each axis. Accumulator width is 17+AVG_LOG2.
  - |−32768| = 32768, with no wrap.
  - Increment the sample counter.
  - On the 2^AVG_LOG2-th accepted sample, go to SCALE_X.
- SCALE_X/Y/Z, one cycle each:
  - avg = acc >> AVG_LOG2 (truncate).
  - prod = avg × SCALE_MUL (33 bits, unsigned).
  - q = prod >> SCALE_SHIFT.
  - Store min(q, 999) in that axis's staging register.
- COMMIT:
  - Load all three staging registers into `data_*` simultaneously.
  - Pulse `data_update`.
  - Clear the accumulators and counter.
  - Return to ACCUM.
- `raw_valid` while `raw_ready` is low:
  - The sample is dropped.
  - `overrun` is set to 1 and cleared only by reset.
  - Accumulation of the current and next window is unaffected.
- `raw_valid` without acceptance never changes the accumulators.
- Reset values: `data_*` = 0, `data_update` = 0, `overrun` = 0, `raw_ready` = 1. Accumulators, counter and staging registers reset to 0.
- Reset mid-operation, in any state: everything returns to reset values immediately. A full fresh window is required afterwards, and no partial update is ever produced.

## Timing
- All outputs except `raw_ready` are registered. `raw_ready` decodes combinationally from the state register.
- Let edge E0 accept the final sample of a window:
  - E1: SCALE_X completes.
  - E2: SCALE_Y completes.
  - E3: SCALE_Z completes.
  - E4: `data_*` change and `data_update` = 1 for exactly one cycle.
- `raw_ready` is low for the four cycles following E0 and high again after E4. A sample on the cycle after E4 is accepted.
- Minimum update period is 2^AVG_LOG2 + 4 cycles.
- `data_*` are held constant between COMMITs. The display stage samples them asynchronously on the pixel clock derived from MAX10_CLK1_50. A mid-frame change is acceptable.

## Structure
- Shared package `accel_pkg` holds:
  - the state enum;
  - `MAX_OUT` = 999;
  - `MAG_W` = 17;
  - `PROD_W` = 33.
- One sub-module, `accel_scale`: a combinational average, multiply, shift and saturate datapath. It is instanced once and time-multiplexed across the three axes by the state machine.
- The top level holds the FSM, accumulators, counter, staging and output registers.

## Test plan
- **Reset:** hold `rst_n` low, then release. `data_*` = 0, `data_update` = 0, `overrun` = 0, `raw_ready` = 1.
- **Nominal window (defaults):** 8 samples of x = 256, y = −256, z = 128. Required: `data_x` = 500, `data_y` = 500, `data_z` = 250, with a single `data_update` pulse exactly 4 cycles after the 8th acceptance.
- **Saturation:** window of x = 512 gives 999 (1000 clamped). Window of x = −32768 gives 999. A window of y = 0 gives 0.
- **Truncation:** x alternating 3, 4 over 8 samples. avg = 3, and 3000 >> 9 gives `data_x` = 5.
- **Overrun:** assert `raw_valid` with x = 30000 during SCALE_Y. The sample is dropped and `overrun` = 1 sticky. The next 8-sample window of x = 256 still yields 500.
- **Reset mid-operation:** pull `rst_n` low in SCALE_Y. Outputs go to 0 immediately. After release, 7 samples produce no update; the 8th produces the correct update.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer conditioning path.
// Holds the FSM state encoding, datapath widths and the sample magnitude helper.
package accel_pkg;

  typedef enum logic [2:0] {
    ST_ACCUM   = 3'd0,
    ST_SCALE_X = 3'd1,
    ST_SCALE_Y = 3'd2,
    ST_SCALE_Z = 3'd3,
    ST_COMMIT  = 3'd4
  } accel_state_e;

  localparam int MAX_OUT = 999;
  localparam int MAG_W   = 17;
  localparam int PROD_W  = 33;

  // One extra bit lets |-32768| come out as 32768 instead of wrapping.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [15:0] v);
    logic [MAG_W-1:0] ext;
    ext = {v[15], v};
    if (v[15]) begin
      abs_mag = 17'd0 - ext;
    end else begin
      abs_mag = ext;
    end
  endfunction

endpackage

// File: rtl/accel_scale.sv
// Combinational average / multiply / shift / saturate datapath, shared across
// the three axes by the conditioner's state machine.
module accel_scale
  import accel_pkg::*;
#(
  parameter int          AVG_LOG2    = 3,
  parameter logic [15:0] SCALE_MUL   = 16'd1000,
  parameter int          SCALE_SHIFT = 9
) (
  input  logic [MAG_W+AVG_LOG2-1:0] acc,
  output logic [15:0]               mag
);

  logic [MAG_W-1:0]  avg_s;
  logic [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0] q_s;

  // Truncating average, then fixed-point scale and clamp to the display range.
  always_comb begin
    avg_s  = MAG_W'(acc >> AVG_LOG2);
    prod_s = PROD_W'(avg_s) * PROD_W'(SCALE_MUL);
    q_s    = prod_s >> SCALE_SHIFT;
    if (q_s > PROD_W'(MAX_OUT)) begin
      mag = 16'(MAX_OUT);
    end else begin
      mag = q_s[15:0];
    end
  end

endmodule

// File: rtl/accel_conditioner.sv
// Box-averages |raw| per axis over 2^AVG_LOG2 samples, scales to 0..999 and
// commits all three axes to the display outputs together.
module accel_conditioner
  import accel_pkg::*;
#(
  parameter int          AVG_LOG2    = 3,
  parameter logic [15:0] SCALE_MUL   = 16'd1000,
  parameter int          SCALE_SHIFT = 9
) (
  input  logic        MAX10_CLK1_50,
  input  logic        rst_n,
  input  logic [15:0] raw_x,
  input  logic [15:0] raw_y,
  input  logic [15:0] raw_z,
  input  logic        raw_valid,
  output logic        raw_ready,
  output logic [15:0] data_x,
  output logic [15:0] data_y,
  output logic [15:0] data_z,
  output logic        data_update,
  output logic        overrun
);

  localparam int ACC_W = MAG_W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] CNT_LAST = {AVG_LOG2{1'b1}};

  accel_state_e        state_q, state_d;
  logic [ACC_W-1:0]    acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_z_q, acc_z_d;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic [15:0]         stage_x_q, stage_x_d, stage_y_q, stage_y_d, stage_z_q, stage_z_d;
  logic [15:0]         data_x_q, data_x_d, data_y_q, data_y_d, data_z_q, data_z_d;
  logic                upd_q, upd_d;
  logic                ovr_q, ovr_d;
  logic [ACC_W-1:0]    scale_acc_s;
  logic [15:0]         scale_mag_s;

  accel_scale #(
    .AVG_LOG2   (AVG_LOG2),
    .SCALE_MUL  (SCALE_MUL),
    .SCALE_SHIFT(SCALE_SHIFT)
  ) u_scale (
    .acc(scale_acc_s),
    .mag(scale_mag_s)
  );

  assign raw_ready   = (state_q == ST_ACCUM);
  assign data_x      = data_x_q;
  assign data_y      = data_y_q;
  assign data_z      = data_z_q;
  assign data_update = upd_q;
  assign overrun     = ovr_q;

  // Next-state, accumulation and staging logic; one axis is scaled per cycle.
  always_comb begin
    state_d     = state_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    acc_z_d     = acc_z_q;
    cnt_d       = cnt_q;
    stage_x_d   = stage_x_q;
    stage_y_d   = stage_y_q;
    stage_z_d   = stage_z_q;
    data_x_d    = data_x_q;
    data_y_d    = data_y_q;
    data_z_d    = data_z_q;
    upd_d       = 1'b0;
    scale_acc_s = acc_x_q;

    if (raw_valid && (state_q != ST_ACCUM)) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_q;
    end

    case (state_q)
      ST_ACCUM: begin
        if (raw_valid) begin
          acc_x_d = acc_x_q + ACC_W'(abs_mag(raw_x));
          acc_y_d = acc_y_q + ACC_W'(abs_mag(raw_y));
          acc_z_d = acc_z_q + ACC_W'(abs_mag(raw_z));
          cnt_d   = cnt_q + AVG_LOG2'(1'b1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_SCALE_X;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_SCALE_X: begin
        scale_acc_s = acc_x_q;
        stage_x_d   = scale_mag_s;
        state_d     = ST_SCALE_Y;
      end
      ST_SCALE_Y: begin
        scale_acc_s = acc_y_q;
        stage_y_d   = scale_mag_s;
        state_d     = ST_SCALE_Z;
      end
      ST_SCALE_Z: begin
        scale_acc_s = acc_z_q;
        stage_z_d   = scale_mag_s;
        state_d     = ST_COMMIT;
      end
      ST_COMMIT: begin
        data_x_d = stage_x_q;
        data_y_d = stage_y_q;
        data_z_d = stage_z_q;
        upd_d    = 1'b1;
        acc_x_d  = {ACC_W{1'b0}};
        acc_y_d  = {ACC_W{1'b0}};
        acc_z_d  = {ACC_W{1'b0}};
        cnt_d    = {AVG_LOG2{1'b0}};
        state_d  = ST_ACCUM;
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACCUM;
      acc_x_q   <= {ACC_W{1'b0}};
      acc_y_q   <= {ACC_W{1'b0}};
      acc_z_q   <= {ACC_W{1'b0}};
      cnt_q     <= {AVG_LOG2{1'b0}};
      stage_x_q <= 16'd0;
      stage_y_q <= 16'd0;
      stage_z_q <= 16'd0;
      data_x_q  <= 16'd0;
      data_y_q  <= 16'd0;
      data_z_q  <= 16'd0;
      upd_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_x_q   <= acc_x_d;
      acc_y_q   <= acc_y_d;
      acc_z_q   <= acc_z_d;
      cnt_q     <= cnt_d;
      stage_x_q <= stage_x_d;
      stage_y_q <= stage_y_d;
      stage_z_q <= stage_z_d;
      data_x_q  <= data_x_d;
      data_y_q  <= data_y_d;
      data_z_q  <= data_z_d;
      upd_q     <= upd_d;
      ovr_q     <= ovr_d;
    end
  end

endmodule

// File: tb/tb_accel_conditioner.sv
// Directed bench for accel_conditioner with default parameters (8-sample window).
module tb_accel_conditioner;

  logic        clk;
  logic        rst_n;
  logic [15:0] raw_x, raw_y, raw_z;
  logic        raw_valid;
  logic        raw_ready;
  logic [15:0] data_x, data_y, data_z;
  logic        data_update;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  accel_conditioner dut (
    .MAX10_CLK1_50(clk),
    .rst_n        (rst_n),
    .raw_x        (raw_x),
    .raw_y        (raw_y),
    .raw_z        (raw_z),
    .raw_valid    (raw_valid),
    .raw_ready    (raw_ready),
    .data_x       (data_x),
    .data_y       (data_y),
    .data_z       (data_z),
    .data_update  (data_update),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Present one sample for exactly one active edge; returns 1 time unit after it.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    raw_x = x; raw_y = y; raw_z = z; raw_valid = 1'b1;
    @(posedge clk); #1;
    raw_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    for (int i = 0; i < n; i++) send(x, y, z);
  endtask

  // Bounded wait for data_update; lat = cycles after the last accept, 0 if no pulse within the bound.
  task automatic wait_update(output int lat, output int rdy_low);
    lat = 0; rdy_low = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (data_update) begin
        lat = i;
        break;
      end
      if (!raw_ready) rdy_low++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; raw_valid = 1'b0; raw_x = 16'd0; raw_y = 16'd0; raw_z = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (data_x !== 16'd0 || data_y !== 16'd0 || data_z !== 16'd0) begin
      errors++; $display("FAIL reset_data: got %0d/%0d/%0d want 0/0/0", data_x, data_y, data_z);
    end
    checks++;
    if (data_update !== 1'b0 || overrun !== 1'b0 || raw_ready !== 1'b1) begin
      errors++; $display("FAIL reset_flags: upd=%b ovr=%b rdy=%b want 0 0 1", data_update, overrun, raw_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal;
    int lat, rdy_low;
    send_n(8, 16'd256, -16'sd256, 16'd128);
    checks++;
    if (raw_ready !== 1'b0) begin
      errors++; $display("FAIL nominal_ready_after_e0: got %b want 0", raw_ready);
    end
    wait_update(lat, rdy_low);
    checks++;
    if (lat != 4 || rdy_low != 3) begin
      errors++; $display("FAIL nominal_latency: got lat=%0d rdy_low=%0d want 4 3", lat, rdy_low);
    end
    checks++;
    if (data_x !== 16'd500 || data_y !== 16'd500 || data_z !== 16'd250) begin
      errors++; $display("FAIL nominal_data: got %0d/%0d/%0d want 500/500/250", data_x, data_y, data_z);
    end
    checks++;
    if (raw_ready !== 1'b1) begin
      errors++; $display("FAIL nominal_ready_after_e4: got %b want 1", raw_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (data_update !== 1'b0 || data_x !== 16'd500) begin
      errors++; $display("FAIL nominal_pulse_width: got upd=%b x=%0d want 0 500", data_update, data_x);
    end
  endtask

  task automatic test_saturation;
    int lat, rdy_low;
    send_n(8, 16'd512, 16'd0, 16'h8000);
    wait_update(lat, rdy_low);
    checks++;
    if (lat != 4 || data_x !== 16'd999 || data_y !== 16'd0 || data_z !== 16'd999) begin
      errors++; $display("FAIL sat_clamp: got lat=%0d %0d/%0d/%0d want 4 999/0/999", lat, data_x, data_y, data_z);
    end
    send_n(8, 16'h8000, 16'd0, 16'd511);
    wait_update(lat, rdy_low);
    checks++;
    if (lat != 4 || data_x !== 16'd999 || data_y !== 16'd0 || data_z !== 16'd998) begin
      errors++; $display("FAIL sat_edge: got lat=%0d %0d/%0d/%0d want 4 999/0/998", lat, data_x, data_y, data_z);
    end
  endtask

  task automatic test_truncation;
    int lat, rdy_low;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send(16'd3, -16'sd3, 16'd4);
      else            send(16'd4, -16'sd4, 16'd4);
    end
    wait_update(lat, rdy_low);
    checks++;
    if (lat != 4 || data_x !== 16'd5 || data_y !== 16'd5 || data_z !== 16'd7) begin
      errors++; $display("FAIL truncation: got lat=%0d %0d/%0d/%0d want 4 5/5/7", lat, data_x, data_y, data_z);
    end
  endtask

  task automatic test_back_to_back;
    int lat, rdy_low;
    send_n(8, 16'd256, 16'd256, 16'd256);
    wait_update(lat, rdy_low);
    checks++;
    if (lat != 4 || data_x !== 16'd500 || data_z !== 16'd500) begin
      errors++; $display("FAIL b2b_first: got lat=%0d %0d/%0d want 4 500/500", lat, data_x, data_z);
    end
    send_n(8, 16'd100, -16'sd200, 16'd300);
    wait_update(lat, rdy_low);
    checks++;
    if (lat != 4 || data_x !== 16'd195 || data_y !== 16'd390 || data_z !== 16'd585) begin
      errors++; $display("FAIL b2b_second: got lat=%0d %0d/%0d/%0d want 4 195/390/585", lat, data_x, data_y, data_z);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_no_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_overrun;
    int lat, rdy_low;
    send_n(8, 16'd128, 16'd128, 16'd128);
    @(posedge clk); #1;                       // now in SCALE_Y
    send(16'd30000, 16'd30000, 16'd30000);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set: got %b want 1", overrun);
    end
    wait_update(lat, rdy_low);
    checks++;
    if (lat != 2 || data_x !== 16'd250) begin
      errors++; $display("FAIL overrun_window: got lat=%0d x=%0d want 2 250", lat, data_x);
    end
    send_n(8, 16'd256, 16'd256, 16'd256);
    wait_update(lat, rdy_low);
    checks++;
    if (lat != 4 || data_x !== 16'd500 || data_y !== 16'd500 || data_z !== 16'd500) begin
      errors++; $display("FAIL overrun_next_window: got lat=%0d %0d/%0d/%0d want 4 500/500/500", lat, data_x, data_y, data_z);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_reset_mid;
    int lat, rdy_low;
    send_n(8, 16'd512, 16'd512, 16'd512);
    @(posedge clk); #1;                       // now in SCALE_Y
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_x !== 16'd0 || data_y !== 16'd0 || data_z !== 16'd0 || overrun !== 1'b0
        || raw_ready !== 1'b1 || data_update !== 1'b0) begin
      errors++; $display("FAIL reset_mid_outputs: got %0d/%0d/%0d ovr=%b rdy=%b upd=%b want 0/0/0 0 1 0",
                         data_x, data_y, data_z, overrun, raw_ready, data_update);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_n(7, 16'd256, 16'd256, 16'd256);
    wait_update(lat, rdy_low);
    checks++;
    if (lat != 0 || data_x !== 16'd0) begin
      errors++; $display("FAIL reset_mid_partial: got lat=%0d x=%0d want 0 0", lat, data_x);
    end
    send(16'd256, 16'd256, 16'd256);
    wait_update(lat, rdy_low);
    checks++;
    if (lat != 4 || data_x !== 16'd500 || data_y !== 16'd500 || data_z !== 16'd500) begin
      errors++; $display("FAIL reset_mid_window: got lat=%0d %0d/%0d/%0d want 4 500/500/500", lat, data_x, data_y, data_z);
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_saturation;
    test_truncation;
    test_back_to_back;
    test_overrun;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
